// File: rtl/dla_axi_lite_arb.sv
// dla_axi_lite_arb: round-robin arbiter that shares one dla_axi_lite_mgr
// between N_REQ requesters. The write and read channels have their own
// grant FSMs and pointers, so one write and one read can be in flight at
// the same time, just as the manager's separate write and read FSMs allow.
module dla_axi_lite_arb #(
  parameter int N_REQ          = 4,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [N_REQ-1:0]                    wr_req_i,
  input  logic [N_REQ*AXI_ADDR_WIDTH-1:0]     wr_addr_i,
  input  logic [N_REQ*AXI_DATA_WIDTH-1:0]     wr_data_i,
  output logic [N_REQ-1:0]                    wr_ack_o,
  input  logic [N_REQ-1:0]                    rd_req_i,
  input  logic [N_REQ*AXI_ADDR_WIDTH-1:0]     rd_addr_i,
  output logic [N_REQ-1:0]                    rd_ack_o,
  output logic [AXI_DATA_WIDTH-1:0]           rd_data_o,
  output logic [1:0]                          mgr_req_o,
  output logic [AXI_ADDR_WIDTH-1:0]           mgr_wr_addr_o,
  output logic [AXI_ADDR_WIDTH-1:0]           mgr_rd_addr_o,
  output logic [AXI_DATA_WIDTH-1:0]           mgr_wr_data_o,
  input  logic [1:0]                          mgr_rsp_i,
  input  logic [AXI_DATA_WIDTH-1:0]           mgr_rd_data_i
);

  localparam int AW = AXI_ADDR_WIDTH;
  localparam int DW = AXI_DATA_WIDTH;
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PW-1:0]    LAST_REQ = PW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_ACK
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA,
    R_ACK
  } rd_state_t;

  // Write channel state. r_wr_ptr doubles as the id of the requester being
  // served, because it is loaded with the grant at the moment of issue.
  wr_state_t         r_wr_state;
  logic [PW-1:0]     r_wr_ptr;
  logic [N_REQ-1:0]  r_wr_ack;
  logic              r_mgr_wr_req;
  logic [AW-1:0]     r_mgr_wr_addr;
  logic [DW-1:0]     r_mgr_wr_data;

  // Read channel state, same arrangement as the write side.
  rd_state_t         r_rd_state;
  logic [PW-1:0]     r_rd_ptr;
  logic [N_REQ-1:0]  r_rd_ack;
  logic [DW-1:0]     r_rd_data;
  logic              r_mgr_rd_req;
  logic [AW-1:0]     r_mgr_rd_addr;

  // Unpacked views of the per-requester address/data slots.
  logic [AW-1:0]     w_wr_addr_arr [N_REQ];
  logic [DW-1:0]     w_wr_data_arr [N_REQ];
  logic [AW-1:0]     w_rd_addr_arr [N_REQ];
  logic [PW-1:0]     w_wr_grant;
  logic [PW-1:0]     w_rd_grant;

  // Round-robin pick: nearest set request after ptr, wrapping. Scanning from
  // the farthest candidate down to the nearest lets the nearest overwrite
  // the others without a separate found flag. With no request set, the
  // result is ptr, which is never used because the FSM only grants on |req.
  function automatic logic [PW-1:0] rrPick(input logic [N_REQ-1:0] req,
                                           input logic [PW-1:0]    ptr);
    logic [PW-1:0] pick;
    logic [PW-1:0] cand;
    pick = ptr;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = PW'((int'(ptr) + i) % N_REQ);
      if (req[cand]) pick = cand;
    end
    return pick;
  endfunction

  for (genvar k = 0; k < N_REQ; k++) begin : g_slot
    assign w_wr_addr_arr[k] = wr_addr_i[k*AW +: AW];
    assign w_wr_data_arr[k] = wr_data_i[k*DW +: DW];
    assign w_rd_addr_arr[k] = rd_addr_i[k*AW +: AW];
  end

  assign w_wr_grant = rrPick(wr_req_i, r_wr_ptr);
  assign w_rd_grant = rrPick(rd_req_i, r_rd_ptr);

  // Write FSM: grant, emit a one-cycle manager request, wait for the
  // manager's write response, then pulse the winner's ack for one cycle.
  // Requests are only sampled in W_IDLE, so a requester dropping its req on
  // the ack edge is never seen again.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_state    <= W_IDLE;
      r_wr_ptr      <= LAST_REQ;
      r_wr_ack      <= '0;
      r_mgr_wr_req  <= 1'b0;
      r_mgr_wr_addr <= '0;
      r_mgr_wr_data <= '0;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          r_wr_ack <= '0;
          if (|wr_req_i) begin
            r_mgr_wr_addr <= w_wr_addr_arr[w_wr_grant];
            r_mgr_wr_data <= w_wr_data_arr[w_wr_grant];
            r_mgr_wr_req  <= 1'b1;
            r_wr_ptr      <= w_wr_grant;
            r_wr_state    <= W_WAIT;
          end
        end
        W_WAIT: begin
          r_mgr_wr_req <= 1'b0;
          if (mgr_rsp_i[0]) begin
            r_wr_ack   <= ONE_HOT0 << r_wr_ptr;
            r_wr_state <= W_ACK;
          end
        end
        W_ACK: begin
          r_wr_ack   <= '0;
          r_wr_state <= W_IDLE;
        end
        default: begin
          r_wr_ack     <= '0;
          r_mgr_wr_req <= 1'b0;
          r_wr_state   <= W_IDLE;
        end
      endcase
    end
  end

  // Read FSM: like the write side, plus an extra R_DATA step because the
  // manager's read-data register only updates on the response edge, so
  // the data is captured one cycle after the response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_state    <= R_IDLE;
      r_rd_ptr      <= LAST_REQ;
      r_rd_ack      <= '0;
      r_rd_data     <= '0;
      r_mgr_rd_req  <= 1'b0;
      r_mgr_rd_addr <= '0;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          r_rd_ack <= '0;
          if (|rd_req_i) begin
            r_mgr_rd_addr <= w_rd_addr_arr[w_rd_grant];
            r_mgr_rd_req  <= 1'b1;
            r_rd_ptr      <= w_rd_grant;
            r_rd_state    <= R_WAIT;
          end
        end
        R_WAIT: begin
          r_mgr_rd_req <= 1'b0;
          if (mgr_rsp_i[1]) begin
            r_rd_state <= R_DATA;
          end
        end
        R_DATA: begin
          r_rd_data  <= mgr_rd_data_i;
          r_rd_ack   <= ONE_HOT0 << r_rd_ptr;
          r_rd_state <= R_ACK;
        end
        R_ACK: begin
          r_rd_ack   <= '0;
          r_rd_state <= R_IDLE;
        end
        default: begin
          r_rd_ack     <= '0;
          r_mgr_rd_req <= 1'b0;
          r_rd_state   <= R_IDLE;
        end
      endcase
    end
  end

  assign wr_ack_o      = r_wr_ack;
  assign rd_ack_o      = r_rd_ack;
  assign rd_data_o     = r_rd_data;
  assign mgr_req_o     = {r_mgr_rd_req, r_mgr_wr_req};
  assign mgr_wr_addr_o = r_mgr_wr_addr;
  assign mgr_wr_data_o = r_mgr_wr_data;
  assign mgr_rd_addr_o = r_mgr_rd_addr;

endmodule

// File: tb/tb_dla_axi_lite_arb.sv
// tb_dla_axi_lite_arb: drives requesters and a small manager model around
// dla_axi_lite_arb and checks grants, manager-side values, acks and ack
// timing against scoreboard queues.
module tb_dla_axi_lite_arb;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int WLAT = 3;
  localparam int RLAT = 4;

  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  logic              clk_i;
  logic              rst_i;
  logic [N-1:0]      wr_req_i;
  logic [N*AW-1:0]   wr_addr_i;
  logic [N*DW-1:0]   wr_data_i;
  logic [N-1:0]      wr_ack_o;
  logic [N-1:0]      rd_req_i;
  logic [N*AW-1:0]   rd_addr_i;
  logic [N-1:0]      rd_ack_o;
  logic [DW-1:0]     rd_data_o;
  logic [1:0]        mgr_req_o;
  logic [AW-1:0]     mgr_wr_addr_o;
  logic [AW-1:0]     mgr_rd_addr_o;
  logic [DW-1:0]     mgr_wr_data_o;
  logic [1:0]        mgr_rsp_i;
  logic [DW-1:0]     mgr_rd_data_i;

  dla_axi_lite_arb #(
    .N_REQ(N),
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .wr_req_i(wr_req_i),
    .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i),
    .wr_ack_o(wr_ack_o),
    .rd_req_i(rd_req_i),
    .rd_addr_i(rd_addr_i),
    .rd_ack_o(rd_ack_o),
    .rd_data_o(rd_data_o),
    .mgr_req_o(mgr_req_o),
    .mgr_wr_addr_o(mgr_wr_addr_o),
    .mgr_rd_addr_o(mgr_rd_addr_o),
    .mgr_wr_data_o(mgr_wr_data_o),
    .mgr_rsp_i(mgr_rsp_i),
    .mgr_rd_data_i(mgr_rd_data_i)
  );

  // Free-running clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  txn_t wrExpQ[$];
  txn_t wrPendQ[$];
  txn_t rdExpQ[$];
  txn_t rdPendQ[$];

  int            wrLeft [N];
  logic [AW-1:0] wrA    [N];
  logic [DW-1:0] wrD    [N];
  int            rdLeft [N];
  logic [AW-1:0] rdA    [N];

  int            cycle = 0;
  int            wrCnt = 0;
  int            rdCnt = 0;
  int            wrRspCycle = 0;
  int            rdRspCycle = 0;
  int            wrIssueCycle = 0;
  int            rdIssueCycle = 0;
  logic          prevWr = 1'b0;
  logic          prevRd = 1'b0;
  logic [DW-1:0] rdRetData = '0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)",
               tag, observed, expected, cycle);
    end
  endtask

  // Raise a level request for requester k; count is how many back-to-back
  // transactions it wants (addr +4 and data +1 after each ack).
  task automatic applyStimulus(input bit isRead, input int k, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input int count);
    if (!isRead) begin
      wrLeft[k] = count;
      wrA[k] = a;
      wrD[k] = d;
      wr_addr_i[k*AW +: AW] = a;
      wr_data_i[k*DW +: DW] = d;
      wr_req_i[k] = 1'b1;
    end else begin
      rdLeft[k] = count;
      rdA[k] = a;
      rd_addr_i[k*AW +: AW] = a;
      rd_req_i[k] = 1'b1;
    end
  endtask

  task automatic expectWr(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.id = id; t.addr = a; t.data = d;
    wrExpQ.push_back(t);
  endtask

  task automatic expectRd(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.id = id; t.addr = a; t.data = d;
    rdExpQ.push_back(t);
  endtask

  // One clock of bench activity at the falling edge: manager model,
  // scoreboard comparisons and requester reactions to acks.
  task automatic tick();
    txn_t t;
    @(negedge clk_i);
    cycle++;
    if (mgr_rsp_i[1]) mgr_rd_data_i = rdRetData;
    mgr_rsp_i = 2'b00;
    if (rst_i) begin
      wrCnt = 0;
      rdCnt = 0;
      mgr_rd_data_i = '0;
      wrPendQ.delete();
      rdPendQ.delete();
      prevWr = 1'b0;
      prevRd = 1'b0;
      return;
    end
    if (wrCnt > 0) begin
      wrCnt--;
      if (wrCnt == 0) begin
        mgr_rsp_i[0] = 1'b1;
        wrRspCycle = cycle;
      end
    end
    if (rdCnt > 0) begin
      rdCnt--;
      if (rdCnt == 0) begin
        mgr_rsp_i[1] = 1'b1;
        rdRspCycle = cycle;
        mgr_rd_data_i = ~rdRetData;
      end
    end
    if (mgr_req_o[0]) begin
      checkOutput("wr_req_pulse", 64'(prevWr), 64'd0);
      if (wrExpQ.size() == 0) begin
        checkOutput("wr_unexpected_req", 64'd1, 64'd0);
      end else begin
        t = wrExpQ.pop_front();
        checkOutput("mgr_wr_addr", 64'(mgr_wr_addr_o), 64'(t.addr));
        checkOutput("mgr_wr_data", 64'(mgr_wr_data_o), 64'(t.data));
        wrPendQ.push_back(t);
        wrCnt = WLAT;
        wrIssueCycle = cycle;
      end
    end
    if (mgr_req_o[1]) begin
      checkOutput("rd_req_pulse", 64'(prevRd), 64'd0);
      if (rdExpQ.size() == 0) begin
        checkOutput("rd_unexpected_req", 64'd1, 64'd0);
      end else begin
        t = rdExpQ.pop_front();
        checkOutput("mgr_rd_addr", 64'(mgr_rd_addr_o), 64'(t.addr));
        rdPendQ.push_back(t);
        rdRetData = t.data;
        rdCnt = RLAT;
        rdIssueCycle = cycle;
      end
    end
    if (wr_ack_o != '0) begin
      if (wrPendQ.size() == 0) begin
        checkOutput("wr_unexpected_ack", 64'(wr_ack_o), 64'd0);
      end else begin
        t = wrPendQ.pop_front();
        checkOutput("wr_ack_vec", 64'(wr_ack_o), 64'd1 << t.id);
        checkOutput("wr_ack_lat", 64'(cycle - wrRspCycle), 64'd1);
        if (wrLeft[t.id] > 0) wrLeft[t.id]--;
        wrA[t.id] = wrA[t.id] + 16'd4;
        wrD[t.id] = wrD[t.id] + 32'd1;
        wr_addr_i[t.id*AW +: AW] = wrA[t.id];
        wr_data_i[t.id*DW +: DW] = wrD[t.id];
        wr_req_i[t.id] = (wrLeft[t.id] > 0);
      end
    end
    if (rd_ack_o != '0) begin
      if (rdPendQ.size() == 0) begin
        checkOutput("rd_unexpected_ack", 64'(rd_ack_o), 64'd0);
      end else begin
        t = rdPendQ.pop_front();
        checkOutput("rd_ack_vec", 64'(rd_ack_o), 64'd1 << t.id);
        checkOutput("rd_data", 64'(rd_data_o), 64'(t.data));
        checkOutput("rd_ack_lat", 64'(cycle - rdRspCycle), 64'd2);
        if (rdLeft[t.id] > 0) rdLeft[t.id]--;
        rdA[t.id] = rdA[t.id] + 16'd4;
        rd_addr_i[t.id*AW +: AW] = rdA[t.id];
        rd_req_i[t.id] = (rdLeft[t.id] > 0);
      end
    end
    prevWr = mgr_req_o[0];
    prevRd = mgr_req_o[1];
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mgr_req"}, 64'(mgr_req_o), 64'd0);
    checkOutput({tag, "_wr_ack"}, 64'(wr_ack_o), 64'd0);
    checkOutput({tag, "_rd_ack"}, 64'(rd_ack_o), 64'd0);
    checkOutput({tag, "_rd_data"}, 64'(rd_data_o), 64'd0);
    checkOutput({tag, "_wr_addr"}, 64'(mgr_wr_addr_o), 64'd0);
    checkOutput({tag, "_wr_data"}, 64'(mgr_wr_data_o), 64'd0);
    checkOutput({tag, "_rd_addr"}, 64'(mgr_rd_addr_o), 64'd0);
  endtask

  // Reset both DUT and bench model; outputs must be zero one edge later.
  task automatic applyReset(input string tag);
    rst_i = 1'b1;
    wr_req_i = '0;
    rd_req_i = '0;
    for (int k = 0; k < N; k++) begin
      wrLeft[k] = 0;
      rdLeft[k] = 0;
    end
    wrExpQ.delete();
    rdExpQ.delete();
    tick();
    checkAllZero(tag);
    tick();
    rst_i = 1'b0;
  endtask

  // Run until every expected transaction has been issued and acked, then
  // idle a few cycles so stray requests or acks are caught.
  task automatic runUntilDone(input string tag, input int budget);
    int n;
    n = 0;
    while ((wrExpQ.size() != 0 || wrPendQ.size() != 0 || rdExpQ.size() != 0 ||
            rdPendQ.size() != 0 || wr_req_i != '0 || rd_req_i != '0) && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, "_completed"}, 64'(n < budget), 64'd1);
    if (n >= budget) begin
      wr_req_i = '0;
      rd_req_i = '0;
      wrExpQ.delete();
      rdExpQ.delete();
    end
    repeat (6) tick();
  endtask

  // Main sequence of directed scenarios.
  initial begin
    int n;
    rst_i = 1'b1;
    wr_req_i = '0;
    rd_req_i = '0;
    wr_addr_i = '0;
    wr_data_i = '0;
    rd_addr_i = '0;
    mgr_rsp_i = '0;
    mgr_rd_data_i = '0;

    // Single write from reset.
    applyReset("reset");
    expectWr(0, 16'h0010, 32'hDEADBEEF);
    applyStimulus(1'b0, 0, 16'h0010, 32'hDEADBEEF, 1);
    runUntilDone("single_wr", 100);

    // Single read by requester 2.
    expectRd(2, 16'h0020, 32'h12345678);
    applyStimulus(1'b1, 2, 16'h0020, 32'h0, 1);
    runUntilDone("single_rd", 100);
    checkOutput("rd_data_hold", 64'(rd_data_o), 64'h12345678);

    // All four writing from reset; requester 0 asks twice.
    applyReset("reset_rr");
    for (int k = 0; k < N; k++) begin
      applyStimulus(1'b0, k, 16'(16'h0100 * (k + 1)), 32'(32'h1000_0000 * (k + 1)), (k == 0) ? 2 : 1);
    end
    expectWr(0, 16'h0100, 32'h1000_0000);
    expectWr(1, 16'h0200, 32'h2000_0000);
    expectWr(2, 16'h0300, 32'h3000_0000);
    expectWr(3, 16'h0400, 32'h4000_0000);
    expectWr(0, 16'h0104, 32'h1000_0001);
    runUntilDone("rr_all", 200);

    // Concurrent write (req1) and read (req3).
    applyReset("reset_conc");
    expectWr(1, 16'h0300, 32'h0BADCAFE);
    expectRd(3, 16'h0330, 32'h33333333);
    applyStimulus(1'b0, 1, 16'h0300, 32'h0BADCAFE, 1);
    applyStimulus(1'b1, 3, 16'h0330, 32'h0, 1);
    runUntilDone("concurrent", 100);
    checkOutput("conc_same_issue", 64'(wrIssueCycle), 64'(rdIssueCycle));

    // Sparse round robin on both channels: after 1, pending {0,3} -> 3 then 0.
    applyReset("reset_sparse");
    expectWr(1, 16'h0500, 32'h5555_0001);
    expectRd(1, 16'h0510, 32'h6666_0001);
    applyStimulus(1'b0, 1, 16'h0500, 32'h5555_0001, 1);
    applyStimulus(1'b1, 1, 16'h0510, 32'h0, 1);
    runUntilDone("sparse_first", 100);
    expectWr(3, 16'h0530, 32'h5555_0003);
    expectWr(0, 16'h0540, 32'h5555_0000);
    expectRd(3, 16'h0550, 32'h6666_0003);
    expectRd(0, 16'h0560, 32'h6666_0000);
    applyStimulus(1'b0, 0, 16'h0540, 32'h5555_0000, 1);
    applyStimulus(1'b0, 3, 16'h0530, 32'h5555_0003, 1);
    applyStimulus(1'b1, 0, 16'h0560, 32'h0, 1);
    applyStimulus(1'b1, 3, 16'h0550, 32'h0, 1);
    runUntilDone("sparse_rr", 200);

    // Reset while the write is waiting on the manager.
    applyReset("reset_pre_abort");
    expectWr(0, 16'h0040, 32'hA5A5A5A5);
    applyStimulus(1'b0, 0, 16'h0040, 32'hA5A5A5A5, 1);
    n = 0;
    while (wrPendQ.size() == 0 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("abort_issued", 64'(wrPendQ.size()), 64'd1);
    tick();
    applyReset("reset_mid_wr");
    runUntilDone("after_abort_quiet", 20);
    expectWr(0, 16'h0044, 32'h5A5A5A5A);
    applyStimulus(1'b0, 0, 16'h0044, 32'h5A5A5A5A, 1);
    runUntilDone("fresh_after_abort", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
